// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: next-PC source encodings used by decode and fetch.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_JR  = 2'd2,
        PC_SRC_J   = 2'd3
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and count saturates at the stack depth.
module ras_stack #(
    parameter int PC_W      = 7,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              din,
    output logic [PC_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic             full;
    logic             empty;

    // ptr names the next free slot, so the newest entry sits one below it.
    assign top_idx = ptr - 1'b1;
    assign top     = mem[top_idx];
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: target select, PC register, stall hold with a
// deferred redirect slot, and return-address prediction.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 7,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_f,
    input  logic                        valid_d,
    input  logic [1:0]                  pc_src_d,
    input  logic [PC_W-1:0]             pc_branch_d,
    input  logic [PC_W-1:0]             jr_target_d,
    input  logic [PC_W-1:0]             jump_target_d,
    input  logic                        call_d,
    input  logic                        ret_d,
    input  logic [PC_W-1:0]             link_d,
    output logic [PC_W-1:0]             pc_f,
    output logic [PC_W-1:0]             pc_plus1_f,
    output logic                        flush_d,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    pc_src_e         src;
    logic            pend_v;
    logic [PC_W-1:0] pend_pc;
    logic            redir;
    logic            ras_hit;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] target;

    assign src        = pc_src_e'(pc_src_d);
    assign pc_plus1_f = pc_f + 1'b1;

    // While a redirect is pending, decode is still showing the instruction that
    // produced it, so it must not be taken a second time.
    assign redir    = valid_d && (src != PC_SRC_SEQ) && !pend_v;
    assign ras_hit  = ret_d && (ras_count != '0);
    assign ras_push = redir && (src == PC_SRC_J) && call_d;
    assign ras_pop  = redir && (src == PC_SRC_JR) && ras_hit;
    assign flush_d  = !rst && (redir || (pend_v && !stall_f));

    always_comb begin
        target = jr_target_d;
        unique case (src)
            PC_SRC_BR:  target = pc_branch_d;
            PC_SRC_J:   target = jump_target_d;
            PC_SRC_JR:  target = ras_hit ? ras_top : jr_target_d;
            PC_SRC_SEQ: target = pc_plus1_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f    <= RESET_PC;
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else if (!stall_f) begin
            if (redir) begin
                pc_f <= target;
            end else if (pend_v) begin
                pc_f <= pend_pc;
            end else begin
                pc_f <= pc_plus1_f;
            end
            pend_v <= 1'b0;
        end else if (redir) begin
            pend_pc <= target;
            pend_v  <= 1'b1;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (link_d),
        .top   (ras_top),
        .count (ras_count)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table plus hand-written stall/reset sequences,
// with expected PC/RAS state queued at drive time and compared after the edge.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    localparam int PC_W      = 7;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_f;
    logic             valid_d;
    logic [1:0]       pc_src_d;
    logic [PC_W-1:0]  pc_branch_d;
    logic [PC_W-1:0]  jr_target_d;
    logic [PC_W-1:0]  jump_target_d;
    logic             call_d;
    logic             ret_d;
    logic [PC_W-1:0]  link_d;
    logic [PC_W-1:0]  pc_f;
    logic [PC_W-1:0]  pc_plus1_f;
    logic             flush_d;
    logic [CNT_W-1:0] ras_count;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .PC_W      (PC_W),
        .RESET_PC  ('0),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .valid_d       (valid_d),
        .pc_src_d      (pc_src_d),
        .pc_branch_d   (pc_branch_d),
        .jr_target_d   (jr_target_d),
        .jump_target_d (jump_target_d),
        .call_d        (call_d),
        .ret_d         (ret_d),
        .link_d        (link_d),
        .pc_f          (pc_f),
        .pc_plus1_f    (pc_plus1_f),
        .flush_d       (flush_d),
        .ras_count     (ras_count)
    );

    typedef struct {
        logic            rst;
        logic            stall;
        logic            valid;
        logic [1:0]      src;
        logic [PC_W-1:0] br;
        logic [PC_W-1:0] jr;
        logic [PC_W-1:0] jt;
        logic            call;
        logic            ret;
        logic [PC_W-1:0] link;
        logic            flush;
        logic [PC_W-1:0] pc;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [CNT_W-1:0] cnt;
        int               id;
    } exp_t;

    exp_t            sb[$];
    vec_t            tbl[$];
    int              checks   = 0;
    int              failures = 0;
    logic [PC_W-1:0] cur_pc;

    function automatic vec_t mk(bit r, bit st, bit v, int src, int br, int jr, int jt,
                                bit call, bit ret, int link, bit fl, int pc, int cnt);
        vec_t x;
        x.rst   = r;
        x.stall = st;
        x.valid = v;
        x.src   = 2'(src);
        x.br    = PC_W'(br);
        x.jr    = PC_W'(jr);
        x.jt    = PC_W'(jt);
        x.call  = call;
        x.ret   = ret;
        x.link  = PC_W'(link);
        x.flush = fl;
        x.pc    = PC_W'(pc);
        x.cnt   = CNT_W'(cnt);
        return x;
    endfunction

    task automatic check(string name, int id, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    task automatic step(vec_t v, int id);
        exp_t            e;
        logic [PC_W-1:0] nxt;
        rst           = v.rst;
        stall_f       = v.stall;
        valid_d       = v.valid;
        pc_src_d      = v.src;
        pc_branch_d   = v.br;
        jr_target_d   = v.jr;
        jump_target_d = v.jt;
        call_d        = v.call;
        ret_d         = v.ret;
        link_d        = v.link;
        #1;
        nxt = cur_pc + 1'b1;
        check("flush_d", id, 32'(flush_d), 32'(v.flush));
        check("pc_plus1_f", id, 32'(pc_plus1_f), 32'(nxt));
        sb.push_back('{pc: v.pc, cnt: v.cnt, id: id});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", id);
        end else begin
            e = sb.pop_front();
            check("pc_f", e.id, 32'(pc_f), 32'(e.pc));
            check("ras_count", e.id, 32'(ras_count), 32'(e.cnt));
            cur_pc = e.pc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_f = 1'b0; valid_d = 1'b0; pc_src_d = 2'd0;
        pc_branch_d = '0; jr_target_d = '0; jump_target_d = '0;
        call_d = 1'b0; ret_d = 1'b0; link_d = '0;
        @(posedge clk);
        #1;
        cur_pc = '0;

        // reset held with a live branch on decode: flush stays low
        step(mk(1,0,1,1, 40,0,0, 0,0,0, 0, 0,0), 100);

        // rst, stall, valid, src, br, jr, jt, call, ret, link, flush, pc, cnt
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0,   1,0));
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0,   2,0));
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0,   3,0));
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0,   4,0));
        tbl.push_back(mk(0,0,1,3,   0, 0, 10, 0,0,0, 1,  10,0));
        tbl.push_back(mk(0,0,1,1,  40, 0,  0, 0,0,0, 1,  40,0));
        tbl.push_back(mk(0,0,0,1,  99, 0,  0, 0,0,0, 0,  41,0));
        tbl.push_back(mk(0,0,1,2,   0,70,  0, 0,0,0, 1,  70,0));
        tbl.push_back(mk(0,0,1,2,   0,33,  0, 0,1,0, 1,  33,0));
        tbl.push_back(mk(0,0,1,0,  90,91, 92, 0,0,0, 0,  34,0));
        tbl.push_back(mk(0,0,1,3,   0, 0,126, 0,0,0, 1, 126,0));
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0, 127,0));
        tbl.push_back(mk(0,0,0,0,   0, 0,  0, 0,0,0, 0,   0,0));
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back(mk(0,0,1,3, 0,0,50+k, 1,0,k, 1, 50+k, (k < 4) ? k : 4));
        end
        tbl.push_back(mk(0,0,1,2,   0,99,  0, 0,1,0, 1,   5,3));
        tbl.push_back(mk(0,0,1,2,   0,99,  0, 0,1,0, 1,   4,2));
        tbl.push_back(mk(0,0,1,2,   0,99,  0, 0,1,0, 1,   3,1));
        tbl.push_back(mk(0,0,1,2,   0,99,  0, 0,1,0, 1,   2,0));
        tbl.push_back(mk(0,0,1,2,   0,99,  0, 0,1,0, 1,  99,0));

        foreach (tbl[i]) begin
            step(tbl[i], i);
        end

        // deferred jal: stalled three cycles, one capture and one push only
        step(mk(0,1,1,3, 0,0,20, 1,0,7, 1, 99,1), 200);
        step(mk(0,1,1,3, 0,0,20, 1,0,7, 0, 99,1), 201);
        step(mk(0,1,1,3, 0,0,20, 1,0,7, 0, 99,1), 202);
        step(mk(0,0,1,3, 0,0,20, 1,0,7, 1, 20,1), 203);
        step(mk(0,0,1,0, 0,0, 0, 0,0,0, 0, 21,1), 204);
        step(mk(0,1,0,0, 0,0, 0, 0,0,0, 0, 21,1), 205);

        // reset while a redirect is pending discards it and empties the RAS
        step(mk(0,1,1,1, 60,0,0, 0,0,0, 1, 21,1), 300);
        step(mk(1,0,0,0,  0,0,0, 0,0,0, 0,  0,0), 301);
        step(mk(0,0,0,0,  0,0,0, 0,0,0, 0,  1,0), 302);
        step(mk(0,0,0,0,  0,0,0, 0,0,0, 0,  2,0), 303);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
